// File: rtl/byte_serializer_pkg.sv
// Shared types and sizing for the byte serializer and its input FIFO.
package byte_serializer_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned FIFO_DEPTH = 2;

    localparam int unsigned BIT_CNT_W  = $clog2(BYTE_W);
    localparam int unsigned SEL_W      = $clog2(NIB_W);
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Reorders a byte so that the bit to be emitted first sits at position 0;
    // the shifter then always shifts right regardless of bit order.
    function automatic logic [BYTE_W-1:0] emit_order(input logic [BYTE_W-1:0] b,
                                                     input bit lsb_first);
        logic [BYTE_W-1:0] r;
        r = b;
        if (!lsb_first) begin
            for (int unsigned i = 0; i < BYTE_W; i++) begin
                r[i] = b[BYTE_W-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/byte_serializer_if.sv
// Byte-stream handshake: a byte moves when valid and ready are both high.
interface byte_serializer_if;
    import byte_serializer_pkg::*;

    logic [BYTE_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (output data, output valid, input  ready);
    modport slave  (input  data, input  valid, output ready);
endinterface

// File: rtl/byte_fifo2.sv
// Two-entry byte FIFO. The write-side ready is a registered "not full" so it
// never depends combinationally on the incoming valid or a same-cycle pop.
module byte_fifo2
    import byte_serializer_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    byte_serializer_if.slave    wr,
    input  logic                pop_i,
    output logic [BYTE_W-1:0]   head_o,
    output logic                empty_o
);

    logic [BYTE_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q,  full_d;
    logic              push;

    assign push     = wr.valid & ~full_q;
    assign wr.ready = ~full_q;
    assign head_o   = mem_q[rd_ptr_q];
    assign empty_o  = (count_q == '0);

    // Occupancy and registered full flag for the next cycle.
    always_comb begin
        count_d = count_q;
        unique case ({push, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == CNT_W'(FIFO_DEPTH));
    end

    // Storage, pointers and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wr.data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

endmodule

// File: rtl/byte_serializer.sv
// Serializes buffered bytes one bit per enable tick, tagging each bit with its
// nibble lane index for a downstream 1-to-4 demultiplexer.
module byte_serializer
    import byte_serializer_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              inClock,
    input  logic              inReset,
    input  logic [BYTE_W-1:0] inByte,
    input  logic              inValid,
    output logic              outReady,
    input  logic              inEnable,
    output logic              outData,
    output logic [SEL_W-1:0]  outSel,
    output logic              outValid,
    output logic              outSymValid,
    output logic              outBusy
);

    byte_serializer_if fifo_bus ();

    logic [BYTE_W-1:0]    fifo_head;
    logic                 fifo_empty;
    logic                 fifo_pop;

    state_e               state_q, state_d;
    logic [BYTE_W-1:0]    shift_q, shift_d;
    logic [BIT_CNT_W-1:0] cnt_q,   cnt_d;
    logic                 data_q,  data_d;
    logic [SEL_W-1:0]     sel_q,   sel_d;
    logic                 valid_q, valid_d;
    logic                 sym_q,   sym_d;
    logic [BYTE_W-1:0]    head_ord;
    logic                 last_bit;

    assign fifo_bus.data  = inByte;
    assign fifo_bus.valid = inValid;
    assign outReady       = fifo_bus.ready;

    byte_fifo2 u_fifo (
        .clk_i   (inClock),
        .rst_ni  (inReset),
        .wr      (fifo_bus.slave),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .empty_o (fifo_empty)
    );

    assign head_ord = emit_order(fifo_head, LSB_FIRST);
    assign last_bit = (cnt_q == BIT_CNT_W'(BYTE_W - 1));

    // State register.
    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: start on a tick with data waiting, stop after the 8th bit
    // only when no further byte is queued.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (inEnable && !fifo_empty) state_d = ST_SHIFT;
            ST_SHIFT: if (inEnable && last_bit && fifo_empty) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output/datapath: cnt_q is the index of the next bit to emit. On the 8th
    // bit the next byte is preloaded with cnt=0 so the following tick has no bubble.
    always_comb begin
        fifo_pop = 1'b0;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        sel_d    = sel_q;
        valid_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                sel_d = '0;
                if (inEnable && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    data_d   = head_ord[0];
                    shift_d  = head_ord >> 1;
                    cnt_d    = BIT_CNT_W'(1);
                    valid_d  = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (inEnable) begin
                    data_d  = shift_q[0];
                    shift_d = shift_q >> 1;
                    sel_d   = cnt_q[SEL_W-1:0];
                    valid_d = 1'b1;
                    if (last_bit) begin
                        cnt_d = '0;
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            shift_d  = head_ord;
                        end else begin
                            shift_d  = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            default: sel_d = '0;
        endcase
        sym_d = valid_d && (sel_d == SEL_W'(NIB_W - 1));
    end

    // Datapath and output registers.
    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) begin
            shift_q <= '0;
            cnt_q   <= '0;
            data_q  <= 1'b0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            sym_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            sym_q   <= sym_d;
        end
    end

    assign outData     = data_q;
    assign outSel      = sel_q;
    assign outValid    = valid_q;
    assign outSymValid = sym_q;
    assign outBusy     = !fifo_empty || (state_q == ST_SHIFT);

endmodule

// File: tb/tb_byte_serializer.sv
// Directed and random stimulus for both bit orders, checked every cycle
// against a queue-based model of the serializer behaviour.
module tb_byte_serializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       ready_m;
    logic       data_l, data_m, valid_l, valid_m, sym_l, sym_m, busy_l, busy_m;
    logic [1:0] sel_l, sel_m;

    byte_serializer_if bus ();

    always #5 clk = ~clk;

    byte_serializer #(.LSB_FIRST(1'b1)) dut_lsb (
        .inClock(clk), .inReset(rst_n), .inByte(bus.data), .inValid(bus.valid),
        .outReady(bus.ready), .inEnable(en), .outData(data_l), .outSel(sel_l),
        .outValid(valid_l), .outSymValid(sym_l), .outBusy(busy_l)
    );

    byte_serializer #(.LSB_FIRST(1'b0)) dut_msb (
        .inClock(clk), .inReset(rst_n), .inByte(bus.data), .inValid(bus.valid),
        .outReady(ready_m), .inEnable(en), .outData(data_m), .outSel(sel_m),
        .outValid(valid_m), .outSymValid(sym_m), .outBusy(busy_m)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state: bytes waiting, byte in service and next bit index.
    logic [7:0] fifo_m[$];
    logic [7:0] cur_b;
    int         cur_n;
    logic       e_data_l, e_data_m, e_valid, e_sym, e_ready, e_busy;
    logic [1:0] e_sel;

    // Captured serial streams for absolute sequence checks.
    logic [15:0] cap_l, cap_m;
    int          ncap;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fifo_m.delete();
        cur_b    = '0;
        cur_n    = 8;
        e_data_l = 1'b0;
        e_data_m = 1'b0;
        e_sel    = 2'd0;
        e_valid  = 1'b0;
        e_sym    = 1'b0;
        e_ready  = 1'b1;
        e_busy   = 1'b0;
    endtask

    task automatic model_edge(input logic t_en, input logic t_vld, input logic [7:0] t_b);
        bit was_idle;
        was_idle = (cur_n == 8);
        e_valid  = 1'b0;
        if (t_en) begin
            if (cur_n == 8 && fifo_m.size() > 0) begin
                cur_b = fifo_m.pop_front();
                cur_n = 0;
            end
            if (cur_n < 8) begin
                e_data_l = cur_b[cur_n];
                e_data_m = cur_b[7 - cur_n];
                e_sel    = 2'(cur_n % 4);
                e_valid  = 1'b1;
                cur_n++;
                if (cur_n == 8 && fifo_m.size() > 0) begin
                    cur_b = fifo_m.pop_front();
                    cur_n = 0;
                end
            end
        end
        if (!e_valid && was_idle) e_sel = 2'd0;
        e_sym = e_valid && (e_sel == 2'd3);
        if (t_vld && e_ready) fifo_m.push_back(t_b);
        e_ready = (fifo_m.size() < 2);
        e_busy  = (fifo_m.size() > 0) || (cur_n < 8);
    endtask

    task automatic check_all();
        chk("ready_lsb", 16'(bus.ready), 16'(e_ready));
        chk("ready_msb", 16'(ready_m),   16'(e_ready));
        chk("data_lsb",  16'(data_l),    16'(e_data_l));
        chk("data_msb",  16'(data_m),    16'(e_data_m));
        chk("sel_lsb",   16'(sel_l),     16'(e_sel));
        chk("sel_msb",   16'(sel_m),     16'(e_sel));
        chk("valid_lsb", 16'(valid_l),   16'(e_valid));
        chk("valid_msb", 16'(valid_m),   16'(e_valid));
        chk("sym_lsb",   16'(sym_l),     16'(e_sym));
        chk("sym_msb",   16'(sym_m),     16'(e_sym));
        chk("busy_lsb",  16'(busy_l),    16'(e_busy));
        chk("busy_msb",  16'(busy_m),    16'(e_busy));
    endtask

    task automatic step(input logic t_en, input logic t_vld, input logic [7:0] t_b);
        en        = t_en;
        bus.valid = t_vld;
        bus.data  = t_b;
        @(posedge clk);
        model_edge(t_en, t_vld, t_b);
        #1;
        check_all();
        if (valid_l === 1'b1) begin
            cap_l = {cap_l[14:0], data_l};
            cap_m = {cap_m[14:0], data_m};
            ncap++;
        end
    endtask

    task automatic clear_cap();
        cap_l = '0;
        cap_m = '0;
        ncap  = 0;
    endtask

    initial begin
        logic accepted;
        rst_n     = 1'b0;
        en        = 1'b0;
        bus.valid = 1'b0;
        bus.data  = '0;
        model_reset();
        clear_cap();
        #2;
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single byte 0xA5, continuous ticks.
        step(1'b1, 1'b1, 8'hA5);
        repeat (10) step(1'b1, 1'b0, 8'h00);
        chk("a5_stream_lsb", cap_l, 16'h00A5);
        chk("a5_stream_msb", cap_m, 16'h00A5);
        chk("a5_bit_count", 16'(ncap), 16'd8);

        // Back-to-back 0x0F, 0xF0: sixteen bits with no gap.
        clear_cap();
        step(1'b1, 1'b1, 8'h0F);
        step(1'b1, 1'b1, 8'hF0);
        repeat (15) step(1'b1, 1'b0, 8'h00);
        chk("b2b_bit_count", 16'(ncap), 16'd16);
        chk("b2b_stream_lsb", cap_l, 16'hF00F);
        chk("b2b_stream_msb", cap_m, 16'h0FF0);
        repeat (3) step(1'b1, 1'b0, 8'h00);

        // No ticks: third byte refused until draining frees a slot.
        step(1'b0, 1'b1, 8'h11);
        step(1'b0, 1'b1, 8'h22);
        repeat (4) step(1'b0, 1'b1, 8'h33);
        accepted = 1'b0;
        for (int i = 0; i < 40 && !accepted; i++) begin
            accepted = (bus.ready === 1'b1);
            step(1'b1, 1'b1, 8'h33);
        end
        chk("third_accept_timeout", 16'(accepted), 16'd1);
        repeat (30) step(1'b1, 1'b0, 8'h00);

        // Tick every fourth cycle.
        step(1'b0, 1'b1, 8'h6C);
        for (int i = 0; i < 44; i++) step((i % 4) == 3, 1'b0, 8'h00);

        // Reset after three bits of 0xFF, then 0x01.
        step(1'b1, 1'b1, 8'hFF);
        repeat (3) step(1'b1, 1'b0, 8'h00);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #2;
        rst_n = 1'b1;
        step(1'b1, 1'b1, 8'h01);
        repeat (12) step(1'b1, 1'b0, 8'h00);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 8'($urandom));
            if (i == 300) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check_all();
                #2;
                rst_n = 1'b1;
            end
        end
        repeat (20) step(1'b1, 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/byte_serializer.md
BYTE_SERIALIZER -- requirements
Module: byte_serializer

Interface
REQ-001 SHALL have parameter LSB_FIRST, default 1; 1 = emit byte bit 0 first, 0 = emit bit 7 first.
REQ-002 SHALL have port inClock  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port inReset  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port inByte  input  8  byte to serialize (PSDU octet).
REQ-005 SHALL have port inValid  input  1  inByte is valid this cycle.
REQ-006 SHALL have port outReady  output  1  block accepts inByte this cycle.
REQ-007 SHALL have port inEnable  input  1  bit-rate tick; at most one bit is emitted per high cycle.
REQ-008 SHALL have port outData  output  1  serial bit for the 1-to-4 lane demultiplexer data input.
REQ-009 SHALL have port outSel  output  2  lane select for that bit, equal to nibble bit index 0..3.
REQ-010 SHALL have port outValid  output  1  one-cycle pulse: outData/outSel updated this cycle.
REQ-011 SHALL have port outSymValid  output  1  one-cycle pulse coincident with outValid when outSel==3 (nibble complete).
REQ-012 SHALL have port outBusy  output  1  high while FIFO non-empty or a byte is partially emitted.

Function
REQ-013 SHALL accept a byte on a rising edge where inValid and outReady are both high.
REQ-014 SHALL buffer accepted bytes in a 2-entry FIFO; outReady SHALL be high iff FIFO is not full, registered, with no combinational path from inValid or a same-cycle pop.
REQ-015 SHALL implement states IDLE (no byte in shifter) and SHIFT (byte in shifter, bit counter 0..7).
REQ-016 IDLE->SHIFT on an edge with inEnable=1 and FIFO non-empty: pop head, present bit 0 of the emit order, counter=1.
REQ-017 In SHIFT, each edge with inEnable=1 SHALL present the next bit; outSel = emitted bit index mod 4.
REQ-018 On the edge emitting the 8th bit: if FIFO non-empty, pop and continue in SHIFT with no bubble on the next tick; otherwise go to IDLE.
REQ-019 With inEnable=0, outData and outSel SHALL hold and outValid/outSymValid SHALL be low.
REQ-020 Latency: byte accepted at edge N with inEnable held high SHALL give its first bit, outValid=1, outSel=0, after edge N+1.
REQ-021 Push into a full FIFO is impossible; a simultaneous push and pop on a 1-entry FIFO SHALL leave 1 entry with FIFO order preserved.
REQ-022 In IDLE, outData SHALL hold its last value and outSel SHALL be 0 after the final bit completes.

Reset
REQ-023 inReset low SHALL asynchronously clear the FIFO, shifter and counter and set state IDLE, outData=0, outSel=0, outValid=0, outSymValid=0, outBusy=0, outReady=1.
REQ-024 Reset mid-byte SHALL discard the partial byte; the first byte after release SHALL start at outSel=0.

Structure
REQ-025 A shared package SHALL hold the state enum, BYTE_W=8, NIB_W=4 and FIFO_DEPTH=2.
REQ-026 The FIFO SHALL be one sub-module, byte_fifo2, with push/pop/full/empty and the same clock and reset.

Verification
REQ-027 LSB_FIRST=1, byte 0xA5, inEnable=1 -> outData 1,0,1,0,0,1,0,1; outSel 0,1,2,3,0,1,2,3; outSymValid on the 4th and 8th bits.
REQ-028 Bytes 0x0F then 0xF0 back-to-back, inEnable=1 -> 16 consecutive outValid pulses with no gap; data 1111000000001111.
REQ-029 inEnable=0, three bytes offered -> two accepted, outReady low from the 3rd; raising inEnable drains both and then the 3rd is accepted.
REQ-030 inEnable high every 4th cycle -> outValid spaced 4 cycles apart; outData/outSel stable in between.
REQ-031 Reset asserted after 3 bits of 0xFF -> all outputs at reset values immediately; next byte 0x01 starts with outSel=0, outData=1.
REQ-032 LSB_FIRST=0, byte 0xA5 -> outData 1,0,1,0,0,1,0,1 (MSB first); outSel 0..3 twice.
